// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared select encoding, ctrl bit index and default-width entry layout for the MEM/WB stage.
package mem_wb_pkg;
  localparam int SEL_ALU = 0;
  localparam int SEL_MEM = 1;
  localparam int SEL_PC  = 2;
  localparam int WE_BIT  = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_SEL_W  = 2;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_DATA_W-1:0] mem;
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_SEL_W:0]    ctrl;
  } mem_wb_entry_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry valid/ready skid buffer; in_ready comes straight from a flop, flush drops all beats.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         acc, move;
  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign acc  = in_valid & ~skid_v_q;
  assign move = ~main_v_q | out_ready;
  // data registers load only on a real transfer so stalled beats never toggle
  always_comb begin
    main_v_d = flush ? 1'b0 : move ? (skid_v_q | acc) : main_v_q;
    skid_v_d = flush ? 1'b0 : move ? 1'b0 : (skid_v_q | acc);
    main_d   = (~flush & move & (skid_v_q | acc)) ? (skid_v_q ? skid_q : in_data) : main_q;
    skid_d   = (~flush & ~move & acc) ? in_data : skid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end
endmodule

// File: rtl/mem_wb_elastic.sv
// mem_wb_elastic: elastic MEM/WB stage with skid buffer, flush and write-back select.
// Define MEM_WB_FWD_EN to add the fwd_valid/fwd_addr/fwd_data forwarding port.
module mem_wb_elastic
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [SEL_W:0]    ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
`ifdef MEM_WB_FWD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] pc_plus4_out
);
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W:0]    ctrl;
  } entry_t;
  entry_t in_e, out_e;
  logic [SEL_W-1:0] sel;
  assign in_e = '{alu: alu_result_in, mem: mem_data_in, pc: pc_plus4_in, addr: wr_addr_in, ctrl: ctrl_in};
  pipe_skid_buf #(.W($bits(entry_t))) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_e),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_e)
  );
  assign sel            = out_e.ctrl[SEL_W:1];
  assign wb_addr        = out_e.addr;
  assign wb_we          = out_valid & out_e.ctrl[WE_BIT] & (out_e.addr != '0);
  assign alu_result_out = out_e.alu;
  assign mem_data_out   = out_e.mem;
  assign pc_plus4_out   = out_e.pc;
  always_comb begin
    wb_data = (sel == SEL_W'(SEL_MEM)) ? out_e.mem : (sel == SEL_W'(SEL_PC)) ? out_e.pc : out_e.alu;
  end
`ifdef MEM_WB_FWD_EN
  assign fwd_valid = wb_we;
  assign fwd_addr  = wb_we ? wb_addr : '0;
  assign fwd_data  = wb_we ? wb_data : '0;
`endif
endmodule

// File: tb/tb_mem_wb_elastic.sv
// tb_mem_wb_elastic: table-driven directed check of the elastic MEM/WB stage.
module tb_mem_wb_elastic;
  logic        clk = 0, rst, in_valid, in_ready, flush, out_valid, out_ready, wb_we;
  logic [31:0] alu_result_in, mem_data_in, pc_plus4_in, wb_data, alu_o, mem_o, pc_o;
  logic [4:0]  wr_addr_in, wb_addr;
  logic [2:0]  ctrl_in;
`ifdef MEM_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  mem_wb_elastic dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_result_in(alu_result_in), .mem_data_in(mem_data_in), .pc_plus4_in(pc_plus4_in),
    .wr_addr_in(wr_addr_in), .ctrl_in(ctrl_in), .out_valid(out_valid), .out_ready(out_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef MEM_WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
    .alu_result_out(alu_o), .mem_data_out(mem_o), .pc_plus4_out(pc_o)
  );
  typedef struct {
    logic v, r, f;
    logic [31:0] alu, mem, pc;
    logic [4:0] addr;
    logic [2:0] ctrl;
    logic e_ir, e_ov, e_we;
    logic [4:0] e_addr;
    logic [31:0] e_data;
  } vec_t;
  vec_t tv[22];
  function automatic vec_t mk(logic v, r, f, logic [31:0] alu, mem, pc, logic [4:0] addr, logic [2:0] ctrl,
                              logic e_ir, e_ov, e_we, logic [4:0] e_addr, logic [31:0] e_data);
    mk = '{v, r, f, alu, mem, pc, addr, ctrl, e_ir, e_ov, e_we, e_addr, e_data};
  endfunction
  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic drive(input logic v, r, f, input logic [31:0] alu, mem, pc, input logic [4:0] addr, input logic [2:0] ctrl);
    in_valid = v; out_ready = r; flush = f; alu_result_in = alu; mem_data_in = mem;
    pc_plus4_in = pc; wr_addr_in = addr; ctrl_in = ctrl;
  endtask
  task automatic check_out(input int idx, input logic ir, ov, we, input logic [4:0] a, input logic [31:0] d);
    chk("in_ready", idx, 32'(in_ready), 32'(ir));
    chk("out_valid", idx, 32'(out_valid), 32'(ov));
    chk("wb_we", idx, 32'(wb_we), 32'(we));
    chk("wb_addr", idx, 32'(wb_addr), 32'(a));
    chk("wb_data", idx, wb_data, d);
`ifdef MEM_WB_FWD_EN
    chk("fwd_valid", idx, 32'(fwd_valid), 32'(we));
    chk("fwd_addr", idx, 32'(fwd_addr), we ? 32'(a) : 32'd0);
    chk("fwd_data", idx, fwd_data, we ? d : 32'd0);
`endif
  endtask
  initial begin
    // streaming, no bubbles
    tv[0]  = mk(1,1,0, 32'h10,0,0, 1, 3'b001, 1,1,1, 1, 32'h10);
    tv[1]  = mk(1,1,0, 32'h11,0,0, 2, 3'b001, 1,1,1, 2, 32'h11);
    tv[2]  = mk(1,1,0, 32'h12,0,0, 3, 3'b001, 1,1,1, 3, 32'h12);
    tv[3]  = mk(1,1,0, 32'h13,0,0, 4, 3'b001, 1,1,1, 4, 32'h13);
    tv[4]  = mk(0,1,0, 0,0,0, 0, 3'b000, 1,0,0, 4, 32'h13);
    // result select 0..3
    tv[5]  = mk(1,1,0, 32'hA,32'hB,32'hC, 5, 3'b001, 1,1,1, 5, 32'hA);
    tv[6]  = mk(1,1,0, 32'hA,32'hB,32'hC, 5, 3'b011, 1,1,1, 5, 32'hB);
    tv[7]  = mk(1,1,0, 32'hA,32'hB,32'hC, 5, 3'b101, 1,1,1, 5, 32'hC);
    tv[8]  = mk(1,1,0, 32'hA,32'hB,32'hC, 5, 3'b111, 1,1,1, 5, 32'hA);
    tv[9]  = mk(0,1,0, 0,0,0, 0, 3'b000, 1,0,0, 5, 32'hA);
    // backpressure: two accepts fill main+skid, third beat waits
    tv[10] = mk(1,0,0, 32'h1,0,0, 6, 3'b001, 1,1,1, 6, 32'h1);
    tv[11] = mk(1,0,0, 32'h2,0,0, 6, 3'b001, 0,1,1, 6, 32'h1);
    tv[12] = mk(1,0,0, 32'h3,0,0, 6, 3'b001, 0,1,1, 6, 32'h1);
    tv[13] = mk(1,1,0, 32'h3,0,0, 6, 3'b001, 1,1,1, 6, 32'h2);
    tv[14] = mk(1,1,0, 32'h3,0,0, 6, 3'b001, 1,1,1, 6, 32'h3);
    tv[15] = mk(0,1,0, 0,0,0, 0, 3'b000, 1,0,0, 6, 32'h3);
    // flush with both entries full and beat 7 offered
    tv[16] = mk(1,0,0, 32'h5,0,0, 7, 3'b001, 1,1,1, 7, 32'h5);
    tv[17] = mk(1,0,0, 32'h6,0,0, 7, 3'b001, 0,1,1, 7, 32'h5);
    tv[18] = mk(1,0,1, 32'h7,0,0, 7, 3'b001, 1,0,0, 7, 32'h5);
    tv[19] = mk(0,1,0, 0,0,0, 0, 3'b000, 1,0,0, 7, 32'h5);
    // write to x0 is suppressed
    tv[20] = mk(1,1,0, 32'h9,0,0, 0, 3'b001, 1,1,0, 0, 32'h9);
    tv[21] = mk(0,1,0, 0,0,0, 0, 3'b000, 1,0,0, 0, 32'h9);
    rst = 1;
    drive(1,0,0, 32'hFF,32'hFF,32'hFF, 5'h1F, 3'b111);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_out(100 + i, 1, 0, 0, 0, 0);
    end
    @(negedge clk) rst = 0;
    drive(0,1,0, 0,0,0, 0, 0);
    @(posedge clk); #1;
    check_out(102, 1, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].r, tv[i].f, tv[i].alu, tv[i].mem, tv[i].pc, tv[i].addr, tv[i].ctrl);
      @(posedge clk); #1;
      check_out(i, tv[i].e_ir, tv[i].e_ov, tv[i].e_we, tv[i].e_addr, tv[i].e_data);
    end
    // reset mid-transfer beats flush and handshake, and clears data
    @(negedge clk) drive(1,0,0, 32'h44,0,0, 3, 3'b001);
    @(posedge clk); #1;
    check_out(200, 1, 1, 1, 3, 32'h44);
    @(negedge clk) drive(1,0,0, 32'h55,0,0, 4, 3'b001);
    @(posedge clk); #1;
    check_out(201, 0, 1, 1, 3, 32'h44);
    @(negedge clk) begin rst = 1; drive(1,1,1, 32'h66,0,0, 2, 3'b001); end
    @(posedge clk); #1;
    check_out(202, 1, 0, 0, 0, 0);
    @(negedge clk) begin rst = 0; drive(0,1,0, 0,0,0, 0, 0); end
    @(posedge clk); #1;
    check_out(203, 1, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
